// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the write-back sequencer.
//   - opcode / funct constants for the instructions the sequencer classifies
//   - destination-register mux and write-data source select encodings
//   - sequencer state encoding and the per-instruction class record
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_PUSH  = 6'h05;
  localparam logic [5:0] FN_POP   = 6'h06;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_SP = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] REGDST_RD = 2'b11;

  localparam logic [1:0] WBSRC_ALU = 2'b00;
  localparam logic [1:0] WBSRC_MEM = 2'b01;
  localparam logic [1:0] WBSRC_PC4 = 2'b10;
  localparam logic [1:0] WBSRC_SP  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MEM_WAIT,
    ST_WB1,
    ST_WB2,
    ST_DONE
  } wb_state_e;

  typedef struct packed {
    logic       needs_mem;
    logic [1:0] wb_count;   // 0, 1 or 2 register writes
    logic [1:0] dst1;
    logic [1:0] src1;
    logic [1:0] dst2;
    logic [1:0] src2;
  } wb_class_t;

endpackage

// File: rtl/wb_instr_classify.sv
// Combinational instruction classifier for the write-back sequencer.
// Ports:
//   opcode  in  6  instruction[31:26]
//   funct   in  6  instruction[5:0]
//   cls     out    {needs_mem, wb_count, dst1, src1, dst2, src2}
// Unrecognised opcodes (and jr) produce no memory access and no writes.
module wb_instr_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output wb_class_t  cls
);

  always_comb begin
    cls = '{needs_mem: 1'b0, wb_count: 2'd0,
            dst1: REGDST_RT, src1: WBSRC_ALU,
            dst2: REGDST_RT, src2: WBSRC_ALU};
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_JR: ;
          FN_PUSH: begin
            cls.needs_mem = 1'b1;
            cls.wb_count  = 2'd1;
            cls.dst1      = REGDST_SP;
            cls.src1      = WBSRC_SP;
          end
          FN_POP: begin
            // Load the popped value first, then adjust the stack pointer.
            cls.needs_mem = 1'b1;
            cls.wb_count  = 2'd2;
            cls.dst1      = REGDST_RT;
            cls.src1      = WBSRC_MEM;
            cls.dst2      = REGDST_SP;
            cls.src2      = WBSRC_SP;
          end
          default: begin
            cls.wb_count = 2'd1;
            cls.dst1     = REGDST_RD;
            cls.src1     = WBSRC_ALU;
          end
        endcase
      end
      OP_ADDI: begin
        cls.wb_count = 2'd1;
        cls.dst1     = REGDST_RT;
        cls.src1     = WBSRC_ALU;
      end
      OP_LW: begin
        cls.needs_mem = 1'b1;
        cls.wb_count  = 2'd1;
        cls.dst1      = REGDST_RT;
        cls.src1      = WBSRC_MEM;
      end
      OP_JAL: begin
        cls.wb_count = 2'd1;
        cls.dst1     = REGDST_RA;
        cls.src1     = WBSRC_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_seq_ctrl.sv
// Write-back sequencer for the register file. Accepts one decoded instruction
// per handshake and steps it through an optional memory wait and one or two
// register write-back cycles.
// Optional feature macro: WB_MEM_TIMEOUT_EN (bounded wait for mem_ready, sets err).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   instr_valid       instruction fields valid (accepted only while idle)
//   opcode, funct     instruction[31:26], instruction[5:0]
//   mem_ready         memory operation complete
//   mem_req           memory request, held until mem_ready
//   reg_dst_sel       00=rt 01=$29 10=$31 11=rd
//   wb_src_sel        00=ALU 01=MEM 10=PC+4 11=SP+/-4
//   reg_write         one-cycle register write strobe per write
//   busy, done, err   sequence status, completion pulse, timeout flag
// All outputs are registered; each is computed from the next state.
module wb_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] wb_src_sel,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       err
);

  wb_state_e  state_q, state_d;
  logic [5:0] op_q, op_d, fn_q, fn_d;
  logic       mem_req_q, mem_req_d;
  logic [1:0] dst_q, dst_d, src_q, src_d;
  logic       reg_write_q, reg_write_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  wb_class_t  cls;

`ifdef WB_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

  // The classifier looks at the latched fields, so its result is stable
  // for the whole sequence regardless of what the inputs do meanwhile.
  wb_instr_classify u_classify (
    .opcode (op_q),
    .funct  (fn_q),
    .cls    (cls)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
`ifdef WB_MEM_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          fn_d    = funct;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.needs_mem)           state_d = ST_MEM_WAIT;
        else if (cls.wb_count != '0) state_d = ST_WB1;
        else                         state_d = ST_DONE;
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_WB1;
        end
`ifdef WB_MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up on this access: no write-back, flag stays until reset.
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_WB1:  state_d = (cls.wb_count == 2'd2) ? ST_WB2 : ST_DONE;
      ST_WB2:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_req_d   = (state_d == ST_MEM_WAIT);
    reg_write_d = (state_d == ST_WB1) || (state_d == ST_WB2);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);

    // Mux selects hold their last value outside the write-back states.
    dst_d = dst_q;
    src_d = src_q;
    if (state_d == ST_WB1) begin
      dst_d = cls.dst1;
      src_d = cls.src1;
    end else if (state_d == ST_WB2) begin
      dst_d = cls.dst2;
      src_d = cls.src2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      dst_q       <= REGDST_RT;
      src_q       <= WBSRC_ALU;
      reg_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef WB_MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      reg_write_q <= reg_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef WB_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Instruction fields are plain data; they are only consumed after a
  // fresh accept, so they need no reset.
  always_ff @(posedge clk) begin
    op_q <= op_d;
    fn_q <= fn_d;
  end

  assign mem_req     = mem_req_q;
  assign reg_dst_sel = dst_q;
  assign wb_src_sel  = src_q;
  assign reg_write   = reg_write_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef WB_MEM_TIMEOUT_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// Directed bench for wb_seq_ctrl. Expected register writes {dst,src} are
// queued when an instruction is issued and popped as reg_write pulses appear.
module tb_wb_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic [1:0] reg_dst_sel;
  logic [1:0] wb_src_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  wb_seq_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .reg_dst_sel (reg_dst_sel),
    .wb_src_sel  (wb_src_sel),
    .reg_write   (reg_write),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the next queued {dst,src}.
  always @(negedge clk) begin
    if (reg_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        check("wr_sel", {28'd0, reg_dst_sel, wb_src_sel}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and follow it to its done pulse. Latency is the
  // number of edges from the accept edge to the edge that samples done=1.
  // While busy, junk is driven on the instruction inputs with instr_valid
  // high; it must have no effect.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int wait_n, input int exp_lat, input int exp_wr,
                           input int exp_mreq, input logic exp_err);
    int cyc, mreq, wr0;
    bit seen;
    wr0 = wr_cnt;
    instr_valid = 1'b1;
    opcode = op;
    funct  = fn;
    step();
    opcode = ~op;
    funct  = ~fn;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    cyc = 0; mreq = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      step();
      cyc++;
      mem_ready = 1'b0;
      if (mem_req) begin
        mreq++;
        if (mreq == wait_n) mem_ready = 1'b1;
      end
      if (done) seen = 1'b1;
    end
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    check({tag, "_latency"}, seen ? 32'(cyc + 1) : 32'd0, 32'(exp_lat));
    check({tag, "_mem_req_cycles"}, 32'(mreq), 32'(exp_mreq));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    step();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_cleared"}, 32'(busy), 32'd0);
    check({tag, "_write_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   32'(mem_req),     32'd0);
    check({tag, "_dst"},       32'(reg_dst_sel), 32'd0);
    check({tag, "_src"},       32'(wb_src_sel),  32'd0);
    check({tag, "_reg_write"}, 32'(reg_write),   32'd0);
    check({tag, "_busy"},      32'(busy),        32'd0);
    check({tag, "_done"},      32'(done),        32'd0);
    check({tag, "_err"},       32'(err),         32'd0);
  endtask

  initial begin
    int wr0, k;
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0; mem_ready = 1'b0;
    repeat (2) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // R-type add: rd <- ALU
    exp_q.push_back(4'b11_00);
    run_instr("rtype_add", 6'h00, 6'h20, 0, 3, 1, 0, 1'b0);

    // lw, memory ready on the third wait cycle
    exp_q.push_back(4'b00_01);
    run_instr("lw", 6'h23, 6'h00, 3, 6, 1, 3, 1'b0);

    // pop: rt <- MEM, then sp <- SP+4
    exp_q.push_back(4'b00_01);
    exp_q.push_back(4'b01_11);
    run_instr("pop", 6'h00, 6'h06, 1, 5, 2, 1, 1'b0);

    // jal: ra <- PC+4
    exp_q.push_back(4'b10_10);
    run_instr("jal", 6'h03, 6'h00, 0, 3, 1, 0, 1'b0);

    // jr: no write; selects keep the jal values
    run_instr("jr", 6'h00, 6'h08, 0, 2, 0, 0, 1'b0);
    check("jr_dst_held", 32'(reg_dst_sel), 32'd2);
    check("jr_src_held", 32'(wb_src_sel), 32'd2);

    // unknown opcode: no write
    run_instr("op3f", 6'h3F, 6'h00, 0, 2, 0, 0, 1'b0);

    // addi: rt <- ALU
    exp_q.push_back(4'b00_00);
    run_instr("addi", 6'h08, 6'h00, 0, 3, 1, 0, 1'b0);

    // push: sp <- SP-4 after the store completes
    exp_q.push_back(4'b01_11);
    run_instr("push", 6'h00, 6'h05, 2, 5, 1, 2, 1'b0);

    // Reset while push sits in memory wait aborts without a write
    wr0 = wr_cnt;
    exp_q.push_back(4'b01_11);
    instr_valid = 1'b1; opcode = 6'h00; funct = 6'h05;
    step();
    instr_valid = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      step();
      k++;
    end
    check("abort_reached_mem_wait", 32'(mem_req), 32'd1);
    step();
    reset = 1'b1;
    step();
    check_reset_outputs("abort");
    exp_q.delete();
    reset = 1'b0;
    mem_ready = 1'b1;
    repeat (6) step();
    mem_ready = 1'b0;
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

`ifdef WB_MEM_TIMEOUT_EN
    // lw with memory never ready: times out after 4 wait cycles
    run_instr("timeout_lw", 6'h23, 6'h00, 1000, 6, 0, 4, 1'b1);
    run_instr("timeout_sticky", 6'h00, 6'h08, 0, 2, 0, 0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("timeout_err_cleared", 32'(err), 32'd0);
`else
    // Without the timeout the sequencer keeps waiting and err stays low
    instr_valid = 1'b1; opcode = 6'h23; funct = 6'h00;
    step();
    instr_valid = 1'b0;
    repeat (20) step();
    check("nowait_limit_mem_req", 32'(mem_req), 32'd1);
    check("nowait_limit_err", 32'(err), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("nowait_reset_busy", 32'(busy), 32'd0);
`endif

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
